// File: rtl/decod_pkg.sv
// Shared constants for the buffered instruction decoder: opcode and addressing-mode
// encodings plus the skid-buffer state type.
package decod_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_STA = 1;
    localparam int OP_LDA = 2;
    localparam int OP_ADD = 3;
    localparam int OP_SUB = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_NOT = 7;
    localparam int OP_J   = 8;
    localparam int OP_JN  = 9;
    localparam int OP_JZ  = 10;
    localparam int OP_IN  = 11;
    localparam int OP_OUT = 12;
    localparam int OP_SHR = 13;
    localparam int OP_SHL = 14;
    localparam int OP_HLT = 15;

    localparam int MODO_DIR = 0;
    localparam int MODO_IND = 1;
    localparam int MODO_IM  = 2;
    localparam int MODO_SOP = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_HALT  = 2'd3
    } buf_state_t;

endpackage

// File: rtl/decod_comb.sv
// Purely combinational word decode: one-hot opcode, one-hot addressing mode,
// operand pass-through, illegal and halt flags.
module decod_comb
    import decod_pkg::*;
#(
    parameter int WORD      = 16,
    parameter int OP_BITS   = 5,
    parameter int N_OPS     = 16,
    parameter int MODE_BITS = 2,
    parameter int HLT_CODE  = OP_HLT
) (
    input  logic [WORD-1:0]                   instrucao,
    output logic [N_OPS-1:0]                  op_onehot,
    output logic [(1<<MODE_BITS)-1:0]         modo_onehot,
    output logic [WORD-OP_BITS-MODE_BITS-1:0] operando,
    output logic                              illegal,
    output logic                              is_hlt
);

    localparam int OP_SPAN = 1 << OP_BITS;
    localparam int MODE_W  = 1 << MODE_BITS;
    localparam int OPND_W  = WORD - OP_BITS - MODE_BITS;

    logic [OP_BITS-1:0]   opcode;
    logic [MODE_BITS-1:0] modo;

    assign opcode   = instrucao[WORD-1 -: OP_BITS];
    assign modo     = instrucao[OPND_W +: MODE_BITS];
    assign operando = instrucao[OPND_W-1:0];
    assign is_hlt   = (opcode == OP_BITS'(HLT_CODE));

    // When the field cannot encode anything past N_OPS there is nothing to flag.
    generate
        if (N_OPS >= OP_SPAN) begin : g_no_illegal
            assign illegal = 1'b0;
        end else begin : g_illegal
            assign illegal = (opcode >= OP_BITS'(N_OPS));
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_OPS; gi++) begin : g_op
            if (gi == OP_NOP) begin : g_nop
                assign op_onehot[gi] = (opcode == OP_BITS'(gi)) || illegal;
            end else begin : g_other
                assign op_onehot[gi] = (opcode == OP_BITS'(gi));
            end
        end
        for (gi = 0; gi < MODE_W; gi++) begin : g_modo
            assign modo_onehot[gi] = (modo == MODE_BITS'(gi));
        end
    endgenerate

endmodule

// File: rtl/decodificador_instrucoes_buf.sv
// Buffered instruction decoder: two-entry skid buffer of decoded words with sticky halt.
// Optional macro DECOD_ILLEGAL_TRAP_EN makes consuming an illegal opcode halt the block.
module decodificador_instrucoes_buf
    import decod_pkg::*;
#(
    parameter int WORD      = 16,
    parameter int OP_BITS   = 5,
    parameter int N_OPS     = 16,
    parameter int MODE_BITS = 2,
    parameter int HLT_CODE  = OP_HLT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              instr_valid,
    output logic                              instr_ready,
    input  logic [WORD-1:0]                   instrucao,
    output logic                              dec_valid,
    input  logic                              dec_ready,
    output logic [N_OPS-1:0]                  op_onehot,
    output logic [(1<<MODE_BITS)-1:0]         modo_onehot,
    output logic [WORD-OP_BITS-MODE_BITS-1:0] operando,
    output logic                              illegal,
    output logic                              halted
);

    localparam int MODE_W = 1 << MODE_BITS;
    localparam int OPND_W = WORD - OP_BITS - MODE_BITS;

    typedef struct packed {
        logic [N_OPS-1:0]  op;
        logic [MODE_W-1:0] modo;
        logic [OPND_W-1:0] opnd;
        logic              ill;
        logic              hlt;
    } entry_t;

    entry_t     new_entry;
    entry_t     head_q, head_d, tail_q, tail_d;
    buf_state_t state_q, state_d;
    logic       instr_ready_q, instr_ready_d;
    logic       dec_valid_q, dec_valid_d;
    logic       halted_q, halted_d;
    logic       accept, consume, head_stop;

    decod_comb #(
        .WORD      (WORD),
        .OP_BITS   (OP_BITS),
        .N_OPS     (N_OPS),
        .MODE_BITS (MODE_BITS),
        .HLT_CODE  (HLT_CODE)
    ) u_decod_comb (
        .instrucao   (instrucao),
        .op_onehot   (new_entry.op),
        .modo_onehot (new_entry.modo),
        .operando    (new_entry.opnd),
        .illegal     (new_entry.ill),
        .is_hlt      (new_entry.hlt)
    );

    assign accept  = instr_valid && instr_ready_q;
    assign consume = dec_valid_q && dec_ready;

`ifdef DECOD_ILLEGAL_TRAP_EN
    logic illegal_sticky_q, illegal_sticky_d;

    assign head_stop        = head_q.hlt || head_q.ill;
    assign illegal_sticky_d = illegal_sticky_q || (consume && head_q.ill);
    assign illegal          = head_q.ill || illegal_sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_sticky_q <= 1'b0;
        end else begin
            illegal_sticky_q <= illegal_sticky_d;
        end
    end
`else
    assign head_stop = head_q.hlt;
    assign illegal   = head_q.ill;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                // A stopping head wins over a same-cycle accept; that word is dropped.
                if (consume && head_stop) begin
                    state_d = ST_HALT;
                end else if (accept && consume) begin
                    head_d = new_entry;
                end else if (accept) begin
                    tail_d  = new_entry;
                    state_d = ST_TWO;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume && head_stop) begin
                    state_d = ST_HALT;
                end else if (consume) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_HALT;
        endcase
        halted_d      = halted_q || (state_d == ST_HALT);
        instr_ready_d = (state_d == ST_EMPTY) || (state_d == ST_ONE);
        dec_valid_d   = (state_d == ST_ONE) || (state_d == ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            head_q        <= '0;
            tail_q        <= '0;
            instr_ready_q <= 1'b1;
            dec_valid_q   <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            instr_ready_q <= instr_ready_d;
            dec_valid_q   <= dec_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign dec_valid   = dec_valid_q;
    assign op_onehot   = head_q.op;
    assign modo_onehot = head_q.modo;
    assign operando    = head_q.opnd;
    assign halted      = halted_q;

endmodule

// File: tb/tb_decodificador_instrucoes_buf.sv
// Directed bench for decodificador_instrucoes_buf; expectations follow DECOD_ILLEGAL_TRAP_EN.
module tb_decodificador_instrucoes_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instrucao;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] op_onehot;
    logic [3:0]  modo_onehot;
    logic [8:0]  operando;
    logic        illegal;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decodificador_instrucoes_buf dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instrucao   (instrucao),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .op_onehot   (op_onehot),
        .modo_onehot (modo_onehot),
        .operando    (operando),
        .illegal     (illegal),
        .halted      (halted)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] op;
        logic [3:0]  modo;
        logic [8:0]  opnd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        dec_ready = 1'b0;
        instrucao = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_head(input string nm, input logic [15:0] op, input logic [8:0] opnd);
        chk({nm, " valid"}, 32'(dec_valid), 32'd1);
        chk({nm, " op"}, 32'(op_onehot), 32'(op));
        chk({nm, " opnd"}, 32'(operando), 32'(opnd));
    endtask

    logic [15:0] w;

    initial begin
        tbl[0] = '{16'h1855, 16'h0008, 4'b0001, 9'h055}; // ADD direct
        tbl[1] = '{16'h13FF, 16'h0004, 4'b0010, 9'h1FF}; // LDA indirect
        tbl[2] = '{16'h3CA5, 16'h0080, 4'b0100, 9'h0A5}; // NOT immediate
        tbl[3] = '{16'h7600, 16'h4000, 4'b1000, 9'h000}; // SHL mode 3
        tbl[4] = '{16'h0100, 16'h0001, 4'b0001, 9'h100}; // NOP
        tbl[5] = '{16'h6203, 16'h1000, 4'b0010, 9'h003}; // OUT indirect

        do_reset();
        chk("rst instr_ready", 32'(instr_ready), 32'd1);
        chk("rst dec_valid", 32'(dec_valid), 32'd0);
        chk("rst op", 32'(op_onehot), 32'd0);
        chk("rst modo", 32'(modo_onehot), 32'd0);
        chk("rst opnd", 32'(operando), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);

        // Single transactions from the table: one-cycle latency, then consume.
        for (int i = 0; i < 6; i++) begin
            instrucao = tbl[i].word;
            instr_valid = 1'b1;
            step();
            instr_valid = 1'b0;
            chk_head($sformatf("vec%0d", i), tbl[i].op, tbl[i].opnd);
            chk($sformatf("vec%0d modo", i), 32'(modo_onehot), 32'(tbl[i].modo));
            chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'd0);
            dec_ready = 1'b1;
            step();
            dec_ready = 1'b0;
            chk($sformatf("vec%0d drained", i), 32'(dec_valid), 32'd0);
        end

        // Streaming eight words with dec_ready high: no bubbles, in order.
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 16'((i + 1) * 2048 + i);
            instrucao = w;
            instr_valid = 1'b1;
            step();
            chk_head($sformatf("stream%0d", i), 16'(1 << (i + 1)), 9'(i));
            chk($sformatf("stream%0d ready", i), 32'(instr_ready), 32'd1);
        end
        instr_valid = 1'b0;
        step();
        chk("stream end valid", 32'(dec_valid), 32'd0);

        // Backpressure: two entries buffered, head held, then drain in order.
        dec_ready = 1'b0;
        instrucao = 16'h1855;
        instr_valid = 1'b1;
        step();
        instrucao = 16'h2011;
        step();
        instrucao = 16'h4022;
        chk("bp full ready", 32'(instr_ready), 32'd0);
        chk_head("bp head A", 16'h0008, 9'h055);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_head($sformatf("bp hold%0d", i), 16'h0008, 9'h055);
            chk($sformatf("bp hold%0d ready", i), 32'(instr_ready), 32'd0);
        end
        dec_ready = 1'b1;
        step();
        chk_head("bp head B", 16'h0010, 9'h011);
        chk("bp reopen ready", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        chk_head("bp head C", 16'h0100, 9'h022);
        step();
        chk("bp empty", 32'(dec_valid), 32'd0);
        dec_ready = 1'b0;

        // Opcode 16 is the first illegal code; reset mid-operation discards it.
        instrucao = 16'h8000;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("op16 op", 32'(op_onehot), 32'h0001);
        chk("op16 illegal", 32'(illegal), 32'd1);
        do_reset();

        // Opcode 20, mode immediate.
        instrucao = 16'hA477;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("op20 op", 32'(op_onehot), 32'h0001);
        chk("op20 modo", 32'(modo_onehot), 32'b0100);
        chk("op20 illegal", 32'(illegal), 32'd1);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk("op20 dec_valid", 32'(dec_valid), 32'd0);
`ifdef DECOD_ILLEGAL_TRAP_EN
        chk("op20 halted", 32'(halted), 32'd1);
        chk("op20 ready", 32'(instr_ready), 32'd0);
        step();
        chk("op20 sticky illegal", 32'(illegal), 32'd1);
        do_reset();
        chk("op20 reset illegal", 32'(illegal), 32'd0);
`else
        chk("op20 halted", 32'(halted), 32'd0);
        chk("op20 ready", 32'(instr_ready), 32'd1);
`endif

        // Reset with two entries buffered.
        instrucao = 16'h1855;
        instr_valid = 1'b1;
        step();
        instrucao = 16'h2011;
        step();
        instr_valid = 1'b0;
        chk("full before rst", 32'(instr_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst dec_valid", 32'(dec_valid), 32'd0);
        chk("midrst ready", 32'(instr_ready), 32'd1);
        chk("midrst op", 32'(op_onehot), 32'd0);
        chk("midrst modo", 32'(modo_onehot), 32'd0);
        chk("midrst opnd", 32'(operando), 32'd0);
        step();
        chk("midrst stays empty", 32'(dec_valid), 32'd0);

        // HLT followed by a queued LDA: LDA must never appear.
        instrucao = 16'h7800;
        instr_valid = 1'b1;
        step();
        instrucao = 16'h1005;
        step();
        chk_head("hlt head", 16'h8000, 9'h000);
        dec_ready = 1'b1;
        step();
        chk("hlt halted", 32'(halted), 32'd1);
        chk("hlt ready", 32'(instr_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hlt no LDA %0d", i), 32'(dec_valid), 32'd0);
            step();
        end
        chk("hlt still halted", 32'(halted), 32'd1);
        chk("hlt still closed", 32'(instr_ready), 32'd0);
        instr_valid = 1'b0;
        do_reset();
        chk("hlt rst halted", 32'(halted), 32'd0);
        chk("hlt rst ready", 32'(instr_ready), 32'd1);

        // HLT in ONE consumed while a new word is accepted: the word is dropped.
        instrucao = 16'h7800;
        instr_valid = 1'b1;
        step();
        instrucao = 16'h1005;
        dec_ready = 1'b1;
        step();
        chk("hlt1 halted", 32'(halted), 32'd1);
        chk("hlt1 dec_valid", 32'(dec_valid), 32'd0);
        step();
        chk("hlt1 dropped", 32'(dec_valid), 32'd0);
        chk("hlt1 ready", 32'(instr_ready), 32'd0);
        instr_valid = 1'b0;
        dec_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
